// File: rtl/tx_start_ctrl_pkg.sv
// Shared types and constants for the transmit start controller slice.
package tx_start_ctrl_pkg;

  localparam int unsigned FRAME_W     = 10;
  localparam int unsigned COUNT_W     = 8;
  localparam int unsigned CLK_FREQ_HZ = 50_000_000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE
  } state_t;

endpackage

// File: rtl/tx_start_ctrl_if.sv
// Start/busy handshake and frame payload between the start controller and the transmitter.
interface tx_start_ctrl_if;
  import tx_start_ctrl_pkg::*;

  logic               TxStart;
  logic               TxBusy;
  logic [FRAME_W-1:0] TxData;

  modport master (output TxStart, output TxData, input TxBusy);
  modport slave  (input TxStart, input TxData, output TxBusy);
endinterface

// File: rtl/tx_start_ctrl_debouncer.sv
// 2-FF synchroniser plus counter debouncer for a board key; emits the stable level and a rise pulse.
module tx_start_ctrl_debouncer #(
  parameter int unsigned DebounceCycles = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned        CNT_W    = (DebounceCycles > 2) ? $clog2(DebounceCycles) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DebounceCycles - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             armed;
  logic [1:0]       settle;
  logic [CNT_W-1:0] cnt;

  // A key held through reset is not reported as a press: rises only count once
  // the synchronised level has been seen released after the pipeline refilled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      armed  <= 1'b0;
      settle <= '0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync1  <= key_raw;
      sync2  <= sync1;
      settle <= {settle[0], 1'b1};
      rise   <= 1'b0;
      if (settle[1] && !sync2) begin
        armed <= 1'b1;
      end
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        rise   <= sync2 & armed;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/tx_start_ctrl.sv
// Debounces the Start key, snapshots the switches and issues one transmit request per press.
module tx_start_ctrl
  import tx_start_ctrl_pkg::*;
#(
  parameter int unsigned DebounceCycles = 500000,
  parameter int unsigned AckTimeout     = 1024,
  parameter bit          StartActiveLow = 1'b0
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Start,
  input  logic [FRAME_W-1:0] SWIn,
  tx_start_ctrl_if.master    tx,
  output logic               Pending,
  output logic [COUNT_W-1:0] FrameCount,
  output logic               Error
);

  localparam int unsigned    TO_W    = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AckTimeout - 1);

  logic start_in;
  logic start_level;
  logic press;

  logic [FRAME_W-1:0] sw_s1;
  logic [FRAME_W-1:0] sw_s2;

  state_t             state_q,     state_d;
  logic               tx_start_q,  tx_start_d;
  logic [FRAME_W-1:0] tx_data_q,   tx_data_d;
  logic               pending_q,   pending_d;
  logic [COUNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               error_q,     error_d;
  logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;

  assign start_in = Start ^ StartActiveLow;

  tx_start_ctrl_debouncer #(
    .DebounceCycles(DebounceCycles)
  ) u_start_db (
    .clk    (CLK),
    .rst_n  (RSTn),
    .key_raw(start_in),
    .level  (start_level),
    .rise   (press)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      sw_s1       <= '0;
      sw_s2       <= '0;
      state_q     <= IDLE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      error_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      sw_s1       <= SWIn;
      sw_s2       <= sw_s1;
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      error_q     <= error_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    error_d     = error_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          tx_data_d = sw_s2;
          pending_d = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (!tx.TxBusy) begin
          tx_start_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx.TxBusy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          error_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx.TxBusy) begin
          frame_cnt_d = frame_cnt_q + COUNT_W'(1);
          pending_d   = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (!start_level) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx.TxStart = tx_start_q;
  assign tx.TxData  = tx_data_q;
  assign Pending    = pending_q;
  assign FrameCount = frame_cnt_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_tx_start_ctrl.sv
// Directed bench for tx_start_ctrl with a small transmitter model driving TxBusy.
module tb_tx_start_ctrl;
  import tx_start_ctrl_pkg::*;

  logic               CLK;
  logic               RSTn;
  logic               Start;
  logic [FRAME_W-1:0] SWIn;
  logic               Pending;
  logic [COUNT_W-1:0] FrameCount;
  logic               Error;

  logic model_busy;
  logic force_busy;
  logic model_en;

  int checks   = 0;
  int failures = 0;

  int               cyc       = 0;
  int               start_cnt = 0;
  int               start_cyc = 0;
  int               pend_cyc  = 0;
  int               err_cyc   = 0;
  logic [FRAME_W-1:0] last_data = '0;
  logic             pend_prev = 1'b0;
  logic             err_prev  = 1'b0;

  tx_start_ctrl_if tx_bus ();

  assign tx_bus.TxBusy = model_busy | force_busy;

  tx_start_ctrl #(
    .DebounceCycles(4),
    .AckTimeout    (8),
    .StartActiveLow(1'b0)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Start     (Start),
    .SWIn      (SWIn),
    .tx        (tx_bus),
    .Pending   (Pending),
    .FrameCount(FrameCount),
    .Error     (Error)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_pending_low(input string tag);
    for (int i = 0; i < 100 && Pending; i++) tick(1);
    check_eq(tag, 32'(Pending), 0);
  endtask

  task automatic run_press(input int hold, input string tag);
    Start = 1'b1;
    tick(hold);
    Start = 1'b0;
    wait_pending_low(tag);
    tick(10);
  endtask

  // Transmitter model: busy one cycle after TxStart, for 12 cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (tx_bus.TxStart && model_en) begin
        @(negedge CLK);
        model_busy = 1'b1;
        repeat (12) @(negedge CLK);
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (tx_bus.TxStart) begin
        start_cnt++;
        start_cyc = cyc;
        last_data = tx_bus.TxData;
      end
      if (Pending && !pend_prev) pend_cyc = cyc;
      pend_prev = Pending;
      if (Error && !err_prev) err_cyc = cyc;
      err_prev = Error;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTn       = 1'b0;
    Start      = 1'b1;
    SWIn       = '0;
    force_busy = 1'b0;
    model_en   = 1'b1;
    tick(3);
    check_eq("rst_txstart",    32'(tx_bus.TxStart), 0);
    check_eq("rst_txdata",     32'(tx_bus.TxData),  0);
    check_eq("rst_pending",    32'(Pending),        0);
    check_eq("rst_framecount", 32'(FrameCount),     0);
    check_eq("rst_error",      32'(Error),          0);

    // Start still held after reset release must not trigger.
    RSTn = 1'b1;
    tick(20);
    check_eq("held_through_reset_starts", start_cnt, 0);
    check_eq("held_through_reset_pending", 32'(Pending), 0);
    Start = 1'b0;
    tick(10);

    SWIn = 10'h2A5;
    run_press(20, "clean_done");
    check_eq("clean_starts",     start_cnt, 1);
    check_eq("clean_data",       32'(last_data), 32'h2A5);
    check_eq("clean_latency",    start_cyc - pend_cyc, 1);
    check_eq("clean_framecount", 32'(FrameCount), 1);
    check_eq("clean_pending",    32'(Pending), 0);

    Start = 1'b1;
    tick(2);
    Start = 1'b0;
    tick(15);
    check_eq("glitch_starts",  start_cnt, 1);
    check_eq("glitch_pending", 32'(Pending), 0);

    Start = 1'b1;
    tick(12);
    SWIn = 10'h155;
    tick(188);
    Start = 1'b0;
    wait_pending_low("hold_done");
    tick(10);
    check_eq("hold_starts",     start_cnt, 2);
    check_eq("hold_data",       32'(last_data), 32'h2A5);
    check_eq("hold_txdata",     32'(tx_bus.TxData), 32'h2A5);
    check_eq("hold_framecount", 32'(FrameCount), 2);

    force_busy = 1'b1;
    SWIn       = 10'h3C3;
    Start      = 1'b1;
    tick(20);
    check_eq("busy_pending",  32'(Pending), 1);
    check_eq("busy_withheld", start_cnt, 2);
    force_busy = 1'b0;
    tick(1);
    check_eq("busy_release_txstart", 32'(tx_bus.TxStart), 1);
    Start = 1'b0;
    wait_pending_low("busy_done");
    tick(10);
    check_eq("busy_framecount", 32'(FrameCount), 3);
    check_eq("busy_data",       32'(last_data), 32'h3C3);

    model_en = 1'b0;
    Start    = 1'b1;
    tick(10);
    Start = 1'b0;
    for (int i = 0; i < 100 && !Error; i++) tick(1);
    tick(10);
    check_eq("timeout_error",      32'(Error), 1);
    check_eq("timeout_delay",      err_cyc - start_cyc, 8);
    check_eq("timeout_pending",    32'(Pending), 0);
    check_eq("timeout_framecount", 32'(FrameCount), 3);
    check_eq("timeout_starts",     start_cnt, 4);

    model_en = 1'b1;
    run_press(10, "recover_done");
    check_eq("recover_framecount", 32'(FrameCount), 4);
    check_eq("recover_error",      32'(Error), 1);

    for (int i = 0; i < 251; i++) run_press(8, "wrap_done");
    check_eq("wrap_255", 32'(FrameCount), 255);
    run_press(8, "wrap_done");
    check_eq("wrap_0",   32'(FrameCount), 0);
    check_eq("wrap_starts", start_cnt, 257);

    RSTn = 1'b0;
    tick(2);
    check_eq("rst2_error",   32'(Error), 0);
    check_eq("rst2_pending", 32'(Pending), 0);
    RSTn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
